// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display: state encoding,
// blank/minus patterns and the active-low seven-segment code table.
package alu_disp_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHOW  = 2'd1,
    OVF   = 2'd2
  } disp_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Entry n is the pattern for hex digit n (bit0=a .. bit6=g, bit7=dp, active-low).
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Absolute value of a 4-bit two's complement number; -8 maps to 4'b1000.
  function automatic logic [3:0] magnitude(input logic [3:0] res);
    magnitude = res[3] ? 4'(~res + 4'd1) : res;
  endfunction

endpackage

// File: rtl/alu_seg_display_seg7_decode.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seg7_decode
  import alu_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/alu_seg_display.sv
// Captures an ALU result on a synchronized button strobe and shows sign,
// magnitude and raw hex digits; value digits blink while the result overflowed.
// Optional history digit of the previous magnitude: define ALU_DISP_HIST_EN.
module alu_seg_display
  import alu_disp_pkg::*;
#(
  parameter int BLINK_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic       i_clr,
  input  logic [3:0] i_res,
  input  logic       i_cout,
  input  logic       i_overflow,
  output logic [7:0] o_seg_sign,
  output logic [7:0] o_seg_mag,
  output logic [7:0] o_seg_hex,
  output logic [7:0] o_seg_prev,
  output logic       o_led_cout,
  output logic       o_led_ovf
);

  logic               sync1_q, sync2_q, dly_q;
  logic               cap;
  disp_state_e        state_q;
  logic [3:0]         res_q;
  logic               cout_q, ovf_q;
  logic [BLINK_W-1:0] presc_q;
  logic [3:0]         mag_nib;
  logic [7:0]         mag_seg, hex_seg;
  logic               shown, blink_off;

  // i_valid is an asynchronous button level: two flops to resolve metastability,
  // a third to detect the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= i_valid;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign cap = sync2_q & ~dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      res_q   <= 4'd0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (i_clr) begin
      state_q <= EMPTY;
    end else if (cap) begin
      state_q <= i_overflow ? OVF : SHOW;
      res_q   <= i_res;
      cout_q  <= i_cout;
      ovf_q   <= i_overflow;
    end
  end

  // Restarting on capture makes the first blink phase after a new value "on".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (cap) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + BLINK_W'(1);
    end
  end

  assign mag_nib   = magnitude(res_q);
  assign shown     = (state_q != EMPTY);
  assign blink_off = (state_q == OVF) && presc_q[BLINK_W-1];

  seg7_decode u_dec_mag (
    .nibble_i (mag_nib),
    .seg_o    (mag_seg)
  );

  seg7_decode u_dec_hex (
    .nibble_i (res_q),
    .seg_o    (hex_seg)
  );

  always_comb begin
    o_seg_sign = SEG_BLANK;
    o_seg_mag  = SEG_BLANK;
    o_seg_hex  = SEG_BLANK;
    if (shown) begin
      o_seg_hex = hex_seg;
      if (!blink_off) begin
        o_seg_sign = res_q[3] ? SEG_MINUS : SEG_BLANK;
        o_seg_mag  = mag_seg;
      end
    end
  end

  assign o_led_cout = shown & cout_q;
  assign o_led_ovf  = shown & ovf_q;

`ifdef ALU_DISP_HIST_EN
  logic [3:0] prev_nib_q;
  logic       prev_vld_q;
  logic [7:0] prev_seg;

  // History keeps the steady magnitude pattern, independent of blink phase;
  // capturing out of EMPTY records a blank digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_nib_q <= 4'd0;
      prev_vld_q <= 1'b0;
    end else if (i_clr) begin
      prev_vld_q <= 1'b0;
    end else if (cap) begin
      prev_nib_q <= mag_nib;
      prev_vld_q <= shown;
    end
  end

  seg7_decode u_dec_prev (
    .nibble_i (prev_nib_q),
    .seg_o    (prev_seg)
  );

  assign o_seg_prev = prev_vld_q ? prev_seg : SEG_BLANK;
`else
  assign o_seg_prev = SEG_BLANK;
`endif

endmodule

// File: tb/tb_alu_seg_display.sv
// Scoreboard bench for alu_seg_display: stimulus queues expected displays per
// cycle; a monitor on the falling edge pops and compares.
module tb_alu_seg_display;

`ifdef ALU_DISP_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_clr = 1'b0;
  logic [3:0] i_res = 4'd0;
  logic       i_cout = 1'b0;
  logic       i_overflow = 1'b0;
  logic [7:0] o_seg_sign, o_seg_mag, o_seg_hex, o_seg_prev;
  logic       o_led_cout, o_led_ovf;

  alu_seg_display #(.BLINK_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_clr      (i_clr),
    .i_res      (i_res),
    .i_cout     (i_cout),
    .i_overflow (i_overflow),
    .o_seg_sign (o_seg_sign),
    .o_seg_mag  (o_seg_mag),
    .o_seg_hex  (o_seg_hex),
    .o_seg_prev (o_seg_prev),
    .o_led_cout (o_led_cout),
    .o_led_ovf  (o_led_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] sign, mag, hex, prev;
    logic       cout, ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input int off, input string tag,
                      input logic [7:0] s, input logic [7:0] m,
                      input logic [7:0] h, input logic [7:0] p,
                      input logic c, input logic o);
    exp_t e;
    e.cyc  = cyc + off;
    e.tag  = tag;
    e.sign = s;
    e.mag  = m;
    e.hex  = h;
    e.prev = HIST ? p : 8'hFF;
    e.cout = c;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] r, input logic c, input logic o);
    i_res      = r;
    i_cout     = c;
    i_overflow = o;
    i_valid    = 1'b1;
  endtask

  task automatic release_valid();
    i_valid = 1'b0;
    cycles(5);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: sample cycle %0d missed, now at %0d", e.tag, e.cyc, cyc);
        end else if (o_seg_sign !== e.sign || o_seg_mag !== e.mag ||
                     o_seg_hex !== e.hex || o_seg_prev !== e.prev ||
                     o_led_cout !== e.cout || o_led_ovf !== e.ovf) begin
          errors++;
          $display("FAIL %s cyc %0d: got sign=%h mag=%h hex=%h prev=%h cout=%b ovf=%b, expected sign=%h mag=%h hex=%h prev=%h cout=%b ovf=%b",
                   e.tag, cyc, o_seg_sign, o_seg_mag, o_seg_hex, o_seg_prev,
                   o_led_cout, o_led_ovf, e.sign, e.mag, e.hex, e.prev, e.cout, e.ovf);
        end else begin
          $display("ok   %s cyc %0d: sign=%h mag=%h hex=%h prev=%h cout=%b ovf=%b",
                   e.tag, cyc, o_seg_sign, o_seg_mag, o_seg_hex, o_seg_prev,
                   o_led_cout, o_led_ovf);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int wait_cnt;
    cycles(2);
    push(1, "in_reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cycles(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 50; k++)
      push(k, "idle", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cycles(52);

    // +5 with carry: blank through the second edge, shown from the third
    strobe(4'b0101, 1'b1, 1'b0);
    push(2, "latency", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    for (int k = 3; k <= 42; k++)
      push(k, "show_5", 8'hFF, 8'h92, 8'h92, 8'hFF, 1'b1, 1'b0);
    cycles(43);
    release_valid();

    // -8 with overflow: sign/mag blink with an 8-cycle half period
    strobe(4'b1000, 1'b0, 1'b1);
    for (int k = 3; k <= 34; k++) begin
      bit on;
      on = ((k - 3) % 16) < 8;
      push(k, "ovf_blink", on ? 8'hBF : 8'hFF, on ? 8'h80 : 8'hFF, 8'h80,
           8'h92, 1'b0, 1'b1);
    end
    cycles(35);
    release_valid();

    // long hold with input changes: one capture only
    strobe(4'b0011, 1'b0, 1'b0);
    for (int k = 3; k <= 100; k++)
      push(k, "hold_once", 8'hFF, 8'hB0, 8'hB0, 8'h80, 1'b0, 1'b0);
    cycles(10);
    i_res = 4'b0111;
    i_overflow = 1'b1;
    cycles(40);
    i_res = 4'b1010;
    i_cout = 1'b1;
    cycles(51);
    release_valid();

    // clear coinciding with capture wins
    strobe(4'b0110, 1'b0, 1'b0);
    cycles(2);
    i_clr = 1'b1;
    for (int k = 1; k <= 8; k++)
      push(k, "clr_and_cap", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cycles(1);
    i_clr = 1'b0;
    cycles(8);
    release_valid();

    strobe(4'b1111, 1'b1, 1'b0);
    for (int k = 3; k <= 12; k++)
      push(k, "neg_1", 8'hBF, 8'hF9, 8'h8E, 8'hFF, 1'b1, 1'b0);
    cycles(13);
    release_valid();

    // history chain then clear
    strobe(4'b0011, 1'b0, 1'b0);
    for (int k = 3; k <= 6; k++)
      push(k, "hist_3", 8'hFF, 8'hB0, 8'hB0, 8'hF9, 1'b0, 1'b0);
    cycles(7);
    release_valid();
    strobe(4'b1110, 1'b1, 1'b0);
    for (int k = 3; k <= 6; k++)
      push(k, "hist_m2", 8'hBF, 8'hA4, 8'h86, 8'hB0, 1'b1, 1'b0);
    cycles(7);
    release_valid();
    i_clr = 1'b1;
    for (int k = 1; k <= 3; k++)
      push(k, "hist_clr", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cycles(1);
    i_clr = 1'b0;
    cycles(3);

    // reset asserted mid-cycle while a value is shown
    strobe(4'b0111, 1'b0, 1'b0);
    push(3, "pre_reset", 8'hFF, 8'hF8, 8'hF8, 8'hFF, 1'b0, 1'b0);
    cycles(4);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    push(1, "async_reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cycles(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++)
      push(k, "post_reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cycles(6);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 200) begin
      cycles(1);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
